// File: rtl/io_input_device.sv
// Memory-mapped key/switch input responder: 2-flop sync, debounce, sticky
// ready/overrun status and a registered interrupt request.

module io_input_group #(
  parameter int             W        = 4,
  parameter logic [W-1:0]   RST_VAL  = '0,
  parameter int             DEBOUNCE = 500000,
  parameter int             CNTBITS  = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] pin,
  input  logic         rd_data,
  input  logic         wr_ctrl,
  input  logic         wr_rdy,
  input  logic         wr_ovr,
  input  logic         wr_ie,
  output logic [W-1:0] stable,
  output logic         rdy,
  output logic         ovr,
  output logic         ie
);

  // The first cycle that sees sync == sync_q already holds two equal samples,
  // so the counter stops one short of DEBOUNCE-1.
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE - 2);

  logic [W-1:0]       meta, sync, sync_q;
  logic [CNTBITS-1:0] cnt;
  logic               settling, chg;

  assign settling = (sync != stable) && (sync == sync_q);
  assign chg      = settling && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= RST_VAL;
      sync   <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta   <= pin;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= RST_VAL;
    end else if (chg) begin
      cnt    <= '0;
      stable <= sync;
    end else if (settling) begin
      cnt    <= cnt + 1'b1;
    end else begin
      cnt    <= '0;
    end
  end

  // A change always sets RDY; OVR only when the previous value was never read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy <= 1'b0;
      ovr <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (chg)
        rdy <= 1'b1;
      else if (rd_data || (wr_ctrl && !wr_rdy))
        rdy <= 1'b0;

      if (chg && rdy && !rd_data)
        ovr <= 1'b1;
      else if (wr_ctrl && !wr_ovr)
        ovr <= 1'b0;

      if (wr_ctrl)
        ie <= wr_ie;
    end
  end

endmodule

module io_input_device #(
  parameter int               DBITS    = 16,
  parameter int               DEBOUNCE = 500000,
  parameter int               CNTBITS  = 20,
  parameter logic [DBITS-1:0] BASE     = 16'hFFF0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             re,
  input  logic             we,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  output logic             irq
);

  typedef struct packed {
    logic [DBITS-1:0] addr;
    logic             re;
    logic             we;
    logic [DBITS-1:0] wdata;
  } bus_req_t;

  bus_req_t   req;
  logic [1:0] idx;
  logic       rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;
  logic [3:0] kstable;
  logic [9:0] sstable;
  logic       krdy, kovr, kie, srdy, sovr, sie;
  logic       unused_bits;

  assign req = '{addr: addr, re: re, we: we, wdata: wdata};
  assign sel = (req.addr[15:3] == BASE[15:3]);
  assign idx = req.addr[2:1];

  assign rd_kdata = sel && req.re && (idx == 2'd0);
  assign rd_sdata = sel && req.re && (idx == 2'd1);
  assign wr_kctrl = sel && req.we && (idx == 2'd2);
  assign wr_sctrl = sel && req.we && (idx == 2'd3);

  assign unused_bits = ^{req.addr[0], req.wdata[DBITS-1:5], req.wdata[3:2]};

  io_input_group #(
    .W(4), .RST_VAL(4'hF), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)
  ) u_key (
    .clk(clk), .reset_n(reset_n), .pin(KEY),
    .rd_data(rd_kdata), .wr_ctrl(wr_kctrl),
    .wr_rdy(req.wdata[0]), .wr_ovr(req.wdata[1]), .wr_ie(req.wdata[4]),
    .stable(kstable), .rdy(krdy), .ovr(kovr), .ie(kie)
  );

  io_input_group #(
    .W(10), .RST_VAL(10'h000), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)
  ) u_sw (
    .clk(clk), .reset_n(reset_n), .pin(SW),
    .rd_data(rd_sdata), .wr_ctrl(wr_sctrl),
    .wr_rdy(req.wdata[0]), .wr_ovr(req.wdata[1]), .wr_ie(req.wdata[4]),
    .stable(sstable), .rdy(srdy), .ovr(sovr), .ie(sie)
  );

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (idx)
        2'd0: rdata = DBITS'(kstable);
        2'd1: rdata = DBITS'(sstable);
        2'd2: rdata = DBITS'({kie, 2'b00, kovr, krdy});
        2'd3: rdata = DBITS'({sie, 2'b00, sovr, srdy});
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= (kie && krdy) || (sie && srdy);
  end

endmodule

// File: tb/tb_io_input_device.sv
// Bench for io_input_device: directed scenarios plus random traffic against a
// sample-window model of the debounce and a rule-level model of the status bits.

module tb_io_input_device;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = 10'h000;
  logic [15:0] addr = 16'h0000;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        sel;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // model state
  logic [3:0] kst;
  logic [9:0] sst;
  logic       krdy, kovr, kie, srdy, sovr, sie, m_irq;
  logic [3:0] khist[$];
  logic [9:0] shist[$];

  io_input_device #(.DBITS(16), .DEBOUNCE(DEB), .CNTBITS(3), .BASE(16'hFFF0)) dut (
    .clk(clk), .reset_n(reset_n), .KEY(KEY), .SW(SW), .addr(addr), .re(re),
    .we(we), .wdata(wdata), .rdata(rdata), .sel(sel), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic exp_sel();
    return addr[15:3] == 13'h1FFE;
  endfunction

  function automatic logic [15:0] exp_rdata();
    if (!exp_sel()) return 16'h0000;
    case (addr[2:1])
      2'd0:    return {12'h000, kst};
      2'd1:    return {6'h00, sst};
      2'd2:    return {11'h000, kie, 2'b00, kovr, krdy};
      default: return {11'h000, sie, 2'b00, sovr, srdy};
    endcase
  endfunction

  task automatic model_reset();
    kst = 4'hF; sst = 10'h000;
    {krdy, kovr, kie, srdy, sovr, sie, m_irq} = '0;
    khist.delete(); shist.delete();
    // the synchronisers hold their reset values, which act as earlier samples
    for (int i = 0; i < DEB + 3; i++) begin
      khist.push_back(4'hF);
      shist.push_back(10'h000);
    end
  endtask

  // A value is accepted once DEB consecutive pin samples, the newest being two
  // edges old (synchroniser delay), all equal it and differ from the stable value.
  task automatic model_step();
    logic       kc, sc, rdk, rds, wk, ws, kset, sset;
    logic [3:0] kv;
    logic [9:0] sv;
    khist.push_back(KEY);
    shist.push_back(SW);
    kv = khist[khist.size() - 3];
    sv = shist[shist.size() - 3];
    kc = (kv != kst);
    sc = (sv != sst);
    for (int k = 0; k < DEB; k++) begin
      if (khist[khist.size() - 3 - k] != kv) kc = 1'b0;
      if (shist[shist.size() - 3 - k] != sv) sc = 1'b0;
    end
    rdk = exp_sel() && re && addr[2:1] == 2'd0;
    rds = exp_sel() && re && addr[2:1] == 2'd1;
    wk  = exp_sel() && we && addr[2:1] == 2'd2;
    ws  = exp_sel() && we && addr[2:1] == 2'd3;
    m_irq = (kie && krdy) || (sie && srdy);
    kset = kc && krdy && !rdk;
    sset = sc && srdy && !rds;
    kovr = kset ? 1'b1 : (wk && !wdata[1]) ? 1'b0 : kovr;
    sovr = sset ? 1'b1 : (ws && !wdata[1]) ? 1'b0 : sovr;
    krdy = kc ? 1'b1 : (rdk || (wk && !wdata[0])) ? 1'b0 : krdy;
    srdy = sc ? 1'b1 : (rds || (ws && !wdata[0])) ? 1'b0 : srdy;
    if (wk) kie = wdata[4];
    if (ws) sie = wdata[4];
    if (kc) kst = kv;
    if (sc) sst = sv;
    while (khist.size() > 16) void'(khist.pop_front());
    while (shist.size() > 16) void'(shist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
    addr = a; re = r; we = w; wdata = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    KEY = 4'hF; SW = 10'h000;
    set_bus(16'hFFF0, 0, 0, 16'h0000);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (rdata !== 16'h000F) begin errors++; $display("FAIL reset_kdata: rdata=%h exp=000f", rdata); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL reset_sel: sel=%b exp=1", sel); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%b exp=0", irq); end
    set_bus(16'hFFF4, 0, 0, 16'h0000);
    #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_kctrl: rdata=%h exp=0000", rdata); end
  endtask

  task automatic test_key_debounce();
    KEY = 4'hE;
    set_bus(16'hFFF0, 0, 0, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (rdata !== ((i < 6) ? 16'h000F : 16'h000E) || rdata !== exp_rdata()) begin
        errors++; $display("FAIL key_accept_c%0d: rdata=%h model=%h", i, rdata, exp_rdata());
      end
    end
    set_bus(16'hFFF4, 0, 0, 16'h0000); #1;
    checks++; if (rdata !== 16'h0001) begin errors++; $display("FAIL key_krdy: rdata=%h exp=0001", rdata); end
    set_bus(16'hFFF0, 1, 0, 16'h0000); tick();
    KEY = 4'hF;
    set_bus(16'hFFF4, 0, 0, 16'h0000); #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL key_read_clr: rdata=%h exp=0000", rdata); end
    repeat (6) tick();
    set_bus(16'hFFF0, 1, 0, 16'h0000); tick();
    set_bus(16'hFFF0, 0, 0, 16'h0000);
    KEY = 4'hE;
    repeat (3) tick();
    KEY = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (rdata !== 16'h000F || rdata !== exp_rdata()) begin
        errors++; $display("FAIL key_glitch_c%0d: rdata=%h model=%h", i, rdata, exp_rdata());
      end
    end
    set_bus(16'hFFF4, 0, 0, 16'h0000); #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL key_glitch_krdy: rdata=%h exp=0000", rdata); end
  endtask

  task automatic test_irq();
    set_bus(16'hFFF4, 0, 1, 16'h0010); tick();
    set_bus(16'hFFF4, 0, 0, 16'h0000);
    KEY = 4'hE;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (irq !== m_irq || rdata !== exp_rdata()) begin
        errors++; $display("FAIL irq_seq_c%0d: irq=%b rdata=%h model irq=%b rdata=%h", i, irq, rdata, m_irq, exp_rdata());
      end
      if (i == 6) begin
        checks++;
        if (rdata !== 16'h0011 || irq !== 1'b0) begin
          errors++; $display("FAIL irq_lag: rdata=%h irq=%b exp 0011/0", rdata, irq);
        end
      end
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b exp=1", irq); end
    set_bus(16'hFFF0, 1, 0, 16'h0000); tick();
    set_bus(16'hFFF4, 0, 0, 16'h0000); #1;
    checks++;
    if (rdata !== 16'h0010 || irq !== 1'b1) begin
      errors++; $display("FAIL irq_read: rdata=%h irq=%b exp 0010/1", rdata, irq);
    end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b exp=0", irq); end
  endtask

  task automatic test_sw_overrun();
    set_bus(16'hFFF6, 0, 0, 16'h0000);
    SW = 10'h3FF;
    repeat (6) tick();
    checks++; if (rdata !== 16'h0001) begin errors++; $display("FAIL sw_rdy: rdata=%h exp=0001", rdata); end
    SW = 10'h001;
    repeat (6) tick();
    checks++;
    if (rdata !== 16'h0003 || rdata !== exp_rdata()) begin
      errors++; $display("FAIL sw_ovr: rdata=%h exp=0003 model=%h", rdata, exp_rdata());
    end
    set_bus(16'hFFF6, 0, 1, 16'h0000); tick();
    set_bus(16'hFFF6, 0, 0, 16'h0000); #1;
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL sw_wclr: rdata=%h exp=0000", rdata); end
  endtask

  task automatic test_same_cycle();
    SW = 10'h2AA;
    repeat (6) tick();
    SW = 10'h155;
    repeat (5) tick();
    set_bus(16'hFFF2, 1, 0, 16'h0000); tick();
    set_bus(16'hFFF6, 0, 0, 16'h0000); #1;
    checks++;
    if (rdata !== 16'h0001 || rdata !== exp_rdata()) begin
      errors++; $display("FAIL same_cycle_sctrl: rdata=%h exp=0001 model=%h", rdata, exp_rdata());
    end
    set_bus(16'hFFF2, 0, 0, 16'h0000); #1;
    checks++; if (rdata !== 16'h0155) begin errors++; $display("FAIL same_cycle_sdata: rdata=%h exp=0155", rdata); end
  endtask

  task automatic test_reset_mid();
    KEY = 4'hF;
    repeat (6) tick();
    KEY = 4'hE;
    repeat (4) tick();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_bus(16'hFFF0, 0, 0, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (rdata !== ((i < 6) ? 16'h000F : 16'h000E) || rdata !== exp_rdata()) begin
        errors++; $display("FAIL reset_mid_c%0d: rdata=%h model=%h", i, rdata, exp_rdata());
      end
    end
    set_bus(16'h1000, 1, 1, 16'h0000); #1;
    checks++;
    if (sel !== 1'b0 || rdata !== 16'h0000) begin
      errors++; $display("FAIL outside_window: sel=%b rdata=%h exp 0/0000", sel, rdata);
    end
    tick();
    set_bus(16'hFFF4, 0, 0, 16'h0000); #1;
    checks++; if (rdata !== 16'h0001) begin errors++; $display("FAIL outside_ignored: rdata=%h exp=0001", rdata); end
  endtask

  task automatic test_random();
    logic [15:0] amap [9] = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF1,
                              16'hFFF5, 16'h1000, 16'hFFE8, 16'hFFF8};
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) KEY = 4'($urandom);
      if ($urandom_range(0, 5) == 0) SW = 10'($urandom);
      set_bus(amap[$urandom_range(0, 8)], ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0), 16'($urandom));
      #1;
      checks++;
      if (rdata !== exp_rdata() || sel !== exp_sel()) begin
        errors++; $display("FAIL rand_read_c%0d: addr=%h rdata=%h sel=%b model=%h/%b", c, addr, rdata, sel, exp_rdata(), exp_sel());
      end
      tick();
      checks++;
      if (irq !== m_irq) begin
        errors++; $display("FAIL rand_irq_c%0d: irq=%b model=%b", c, irq, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_debounce();
    test_irq();
    test_sw_overrun();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_device.md
Name: io_input_device

Overview:
- Memory-mapped responder for the board's push-keys and slide switches. It answers processor data-memory reads and writes in the 16'hFFF0–16'hFFF7 window.
- It synchronises and debounces the raw KEY/SW pins and flags state changes with sticky ready/overrun bits.
- It raises an interrupt request for the system-register interrupt logic.
- It replaces direct raw-pin muxing at FFF0/FFF2. Read data keeps the same raw polarity, so existing polling code still works.

Parameters:
- DBITS, 16, data bus width.
- DEBOUNCE, 500000, consecutive stable cycles required before a change is accepted (10 ms at 50 MHz).
- CNTBITS, 20, width of each debounce counter; must satisfy 2^CNTBITS > DEBOUNCE.
- BASE, 16'hFFF0, base address of the 4-register window.

Ports:
- clk  input  1  system clock (the PLL clock shared with the processor).
- reset_n  input  1  reset, asynchronous, active-low.
- KEY  input  4  raw push-keys, active-low (1 = released).
- SW  input  10  raw switches.
- addr  input  DBITS  data memory address (M stage).
- re  input  1  read strobe; qualifies read side effects.
- we  input  1  write strobe.
- wdata  input  DBITS  write data.
- rdata  output  DBITS  read data, combinational from addr.
- sel  output  1  addr lies in the window; steers the external read mux.
- irq  output  1  interrupt request, registered.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Register map (byte addresses; addr[0] ignored):
  - BASE+0 KDATA: read-only. {12'b0, kstable[3:0]}.
  - BASE+2 SDATA: read-only. {6'b0, sstable[9:0]}.
  - BASE+4 KCTRL: bit0 KRDY, bit1 KOVR, bit4 KIE. All other bits read 0.
  - BASE+6 SCTRL: same layout for the switches (SRDY, SOVR, SIE).
- Decode: sel = (addr[15:3] == BASE[15:3]). When sel = 0, rdata = 0 and strobes are ignored.
- Synchroniser: each input group passes through a 2-flop synchroniser.
  - Reset values: keys 4'hF, switches 10'h0.
- Debounce, per group (one counter each):
  - If sync != stable and sync == the previous cycle's sync, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE-1, stable <= sync, the counter clears, and a one-cycle change pulse is raised.
  - Latency from the pin change to the stable update is 2 + DEBOUNCE cycles.
  - Any glitch shorter than DEBOUNCE cycles never reaches stable.
- Ready/overrun, per group (bits are sticky):
  - A change pulse sets RDY. If RDY is already 1 at the pulse, OVR is also set.
  - An re read of the group's DATA register clears RDY at the clock edge.
  - Same-cycle change pulse and DATA read: RDY stays 1 (set wins). OVR is not set, because the read consumed the old value.
  - A write to CTRL loads the IE bit from wdata[4].
  - Writing 0 to bit0 or bit1 clears RDY or OVR respectively. Writing 1 has no effect, and the set still wins in the same cycle.
  - Writes to DATA registers are ignored. Reads of CTRL have no side effects.
- Interrupt:
  - irq <= (KIE & KRDY) | (SIE & SRDY), registered, so it follows the bit change by one cycle.
  - It stays high until software clears RDY (by a DATA read or a CTRL write) or clears IE.
- Reset values: kstable 4'hF, sstable 10'h0, counters 0, all RDY/OVR/IE 0, irq 0.
- Reset mid-debounce discards the partial count. No change pulse is generated by reset release.
- Simultaneous re and we to the same address: a write to CTRL applies, a read of CTRL has no side effect, and a write to DATA is ignored while the read of DATA still clears RDY.

Test Plan:
- Reset, DEBOUNCE=4, KEY=4'hF: read BASE+0 -> 16'h000F. Read BASE+4 -> 16'h0000. irq=0.
- KEY 4'hF->4'hE held: after 2+4 cycles KDATA=16'h000E and KCTRL=16'h0001. A KEY pulse of 3 cycles (then back to 4'hF) -> KDATA unchanged and KRDY=0.
- Write 16'h0010 to BASE+4, then press key0 -> irq=1 one cycle after KRDY sets. Read BASE+0 with re -> KRDY=0 and irq=0 one cycle later.
- SW 0->10'h3FF accepted, then SW->10'h001 accepted without a read -> SCTRL=16'h0003. Write 16'h0000 to BASE+6 -> SCTRL=16'h0000.
- A change pulse coincides with an re read of BASE+2 -> SRDY=1, SOVR=0, SDATA shows the new value.
- Assert reset_n=0 mid-count (2 of 4), release with KEY stable at 4'hE -> the full 2+4 cycles are required again. addr=16'h1000 -> sel=0, rdata=0.
